// File: rtl/vga_image_pixel_path.sv
// Grayscale image pixel path behind the VGA timing generator: ROM fetch, frame-synchronous brightness, RGB332 out.
// Optional build macro IMG_INVERT_EN adds a synchronized 'invert' input that negates the pixel after clamping.
module vga_image_pixel_path #(
   parameter int IMG_W   = 128,
   parameter int IMG_H   = 128,
   parameter int ADDR_W  = 14,
   parameter int H_START = 145,
   parameter int V_START = 32,
   parameter int STEP    = 16
) (
   input  logic              clk,
   input  logic              clear,
   input  logic [9:0]        hcount,
   input  logic [9:0]        vcount,
   input  logic              video_on,
   input  logic              hsync_in,
   input  logic              vsync_in,
   input  logic              btn_up,
   input  logic              btn_dn,
`ifdef IMG_INVERT_EN
   input  logic              invert,
`endif
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [7:0]        rom_data,
   output logic              hsync,
   output logic              vsync,
   output logic [2:0]        red,
   output logic [2:0]        green,
   output logic [1:0]        blue,
   output logic [8:0]        brightness
);

   localparam int XB = $clog2(IMG_W);

   typedef enum logic [1:0] {REQ_NONE, REQ_UP, REQ_DN} req_t;

   logic [9:0]        x, y;
   logic              in_img;
   logic              s0_in, s0_vid, s0_hs, s0_vs;
   logic              s1_in, s1_vid, s1_hs, s1_vs;
   logic signed [9:0] sum;
   logic [7:0]        p, pix;
   logic              up_meta, up_sync, up_prev, dn_meta, dn_sync, dn_prev;
   logic              up_edge, dn_edge, frame_start;
   req_t              pending, new_req;
   logic signed [9:0] bright_ext, up_sum, dn_sum;

   assign x = hcount - 10'(H_START);
   assign y = vcount - 10'(V_START);
   assign in_img = video_on && (hcount >= 10'(H_START)) && (x < 10'(IMG_W))
                   && (vcount >= 10'(V_START)) && (y < 10'(IMG_H));

   // Three register stages: address, ROM's own output register, colour; flags ride alongside
   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         rom_addr <= '0;
         {s0_in, s0_vid, s0_hs, s0_vs} <= '0;
         {s1_in, s1_vid, s1_hs, s1_vs} <= '0;
         {hsync, vsync} <= '0;
         red   <= '0;
         green <= '0;
         blue  <= '0;
      end else begin
         if (in_img)
            rom_addr <= ADDR_W'({y, x[XB-1:0]});
         {s0_in, s0_vid, s0_hs, s0_vs} <= {in_img, video_on, hsync_in, vsync_in};
         {s1_in, s1_vid, s1_hs, s1_vs} <= {s0_in, s0_vid, s0_hs, s0_vs};
         {hsync, vsync} <= {s1_hs, s1_vs};
         if (s1_in && s1_vid) begin
            red   <= pix[7:5];
            green <= pix[7:5];
            blue  <= pix[7:6];
         end else begin
            red   <= '0;
            green <= '0;
            blue  <= '0;
         end
      end
   end

   assign bright_ext = {brightness[8], brightness};
   assign sum = $signed({2'b00, rom_data}) + bright_ext;

   always_comb begin
      p = sum[7:0];
      if (sum < 10'sd0)
         p = 8'h00;
      else if (sum > 10'sd255)
         p = 8'hFF;
   end

`ifdef IMG_INVERT_EN
   logic inv_meta, inv_sync;

   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         inv_meta <= 1'b0;
         inv_sync <= 1'b0;
      end else begin
         inv_meta <= invert;
         inv_sync <= inv_meta;
      end
   end

   assign pix = inv_sync ? ~p : p;
`else
   assign pix = p;
`endif

   // Buttons are asynchronous levels: synchronize, then keep one more flop for edge detection
   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         {up_meta, up_sync, up_prev} <= '0;
         {dn_meta, dn_sync, dn_prev} <= '0;
      end else begin
         {up_meta, up_sync, up_prev} <= {btn_up, up_meta, up_sync};
         {dn_meta, dn_sync, dn_prev} <= {btn_dn, dn_meta, dn_sync};
      end
   end

   assign up_edge     = up_sync && !up_prev;
   assign dn_edge     = dn_sync && !dn_prev;
   assign frame_start = (hcount == 10'd0) && (vcount == 10'd0);
   assign up_sum      = bright_ext + $signed(10'(STEP));
   assign dn_sum      = bright_ext - $signed(10'(STEP));

   always_comb begin
      new_req = REQ_NONE;
      if (up_edge && !dn_edge)
         new_req = REQ_UP;
      else if (dn_edge && !up_edge)
         new_req = REQ_DN;
   end

   // Offset only moves at the top-left of the frame; an edge seen on that same cycle waits a frame
   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         pending    <= REQ_NONE;
         brightness <= '0;
      end else if (frame_start) begin
         if (pending == REQ_UP)
            brightness <= (up_sum > 10'sd127) ? 9'd127 : up_sum[8:0];
         else if (pending == REQ_DN)
            brightness <= (dn_sum < -10'sd128) ? 9'h180 : dn_sum[8:0];
         pending <= new_req;
      end else if (new_req != REQ_NONE) begin
         pending <= new_req;
      end
   end

endmodule

// File: tb/tb_vga_image_pixel_path.sv
// Self-checking bench for vga_image_pixel_path: vector table, directed brightness/reset sequences, random lines vs. a reference model.
module tb_vga_image_pixel_path;

   localparam int IMG_W   = 128;
   localparam int IMG_H   = 128;
   localparam int H_START = 145;
   localparam int V_START = 32;
   localparam int STEP    = 16;

   logic       clk = 1'b0;
   logic       clear;
   logic [9:0] hcount, vcount;
   logic       video_on, hsync_in, vsync_in, btn_up, btn_dn;
   logic [13:0] rom_addr;
   logic [7:0] rom_data;
   logic       hsync, vsync;
   logic [2:0] red, green;
   logic [1:0] blue;
   logic [8:0] brightness;
`ifdef IMG_INVERT_EN
   logic       invert = 1'b0;
`endif

   vga_image_pixel_path dut (
      .clk(clk), .clear(clear), .hcount(hcount), .vcount(vcount),
      .video_on(video_on), .hsync_in(hsync_in), .vsync_in(vsync_in),
      .btn_up(btn_up), .btn_dn(btn_dn),
`ifdef IMG_INVERT_EN
      .invert(invert),
`endif
      .rom_addr(rom_addr), .rom_data(rom_data), .hsync(hsync), .vsync(vsync),
      .red(red), .green(green), .blue(blue), .brightness(brightness)
   );

   always #5 clk = ~clk;

   // Synchronous image ROM: data valid one cycle after the address
   logic [7:0] rom_mem [0:16383];
   always @(posedge clk) rom_data <= rom_mem[rom_addr];

   int checks = 0;
   int failures = 0;
   int model_bright = 0;
   int model_pending = 0;

   typedef struct {bit in_img; int addr; bit hs; bit vs;} exp_t;
   exp_t pipe[$];

   typedef struct {int h; int v; bit von; int data; int r; int g; int b;} vec_t;

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
      end
   endtask

   function automatic bit inImage(input int h, input int v, input bit von);
      return von && h >= H_START && h < H_START + IMG_W && v >= V_START && v < V_START + IMG_H;
   endfunction

   task automatic compareFront();
      exp_t e;
      int s;
      e = pipe.pop_front();
      s = e.in_img ? int'(rom_mem[e.addr]) + model_bright : 0;
      if (s < 0) s = 0;
      if (s > 255) s = 255;
      checkOutput("model_red",   int'(red),   e.in_img ? s / 32 : 0);
      checkOutput("model_green", int'(green), e.in_img ? s / 32 : 0);
      checkOutput("model_blue",  int'(blue),  e.in_img ? s / 64 : 0);
      checkOutput("model_hsync", int'(hsync), int'(e.hs));
      checkOutput("model_vsync", int'(vsync), int'(e.vs));
   endtask

   // One pixel clock with the given counter/sync inputs; model compares the pixel from two ticks earlier
   task automatic applyStimulus(input int h, input int v, input bit von, input bit hs, input bit vs);
      exp_t e;
      hcount = 10'(h);
      vcount = 10'(v);
      video_on = von;
      hsync_in = hs;
      vsync_in = vs;
      @(posedge clk);
      #1;
      e.in_img = inImage(h, v, von);
      e.addr = (v - V_START) * IMG_W + (h - H_START);
      e.hs = hs;
      e.vs = vs;
      if (e.in_img) checkOutput("rom_addr", int'(rom_addr), e.addr);
      pipe.push_back(e);
      if (pipe.size() == 3) compareFront();
      if (h == 0 && v == 0) begin
         if (model_pending == 1) model_bright = (model_bright + STEP > 127) ? 127 : model_bright + STEP;
         if (model_pending == 2) model_bright = (model_bright - STEP < -128) ? -128 : model_bright - STEP;
         model_pending = 0;
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(700, 600, 1'b0, 1'b1, 1'b1);
   endtask

   task automatic press(input bit up, input bit dn);
      btn_up = up;
      btn_dn = dn;
      idle(4);
      btn_up = 1'b0;
      btn_dn = 1'b0;
      idle(4);
      if (up && !dn) model_pending = 1;
      if (dn && !up) model_pending = 2;
   endtask

   task automatic applyFrame();
      applyStimulus(0, 0, 1'b0, 1'b1, 1'b1);
      idle(3);
   endtask

   task automatic checkPixel(input string name, input int h, input int v, input int data,
                             input int r, input int g, input int b);
      rom_mem[(v - V_START) * IMG_W + (h - H_START)] = 8'(data);
      applyStimulus(h, v, 1'b1, 1'b0, 1'b0);
      idle(2);
      checkOutput({name, "_red"}, int'(red), r);
      checkOutput({name, "_green"}, int'(green), g);
      checkOutput({name, "_blue"}, int'(blue), b);
   endtask

   vec_t vecs[9];
   int   ups[9];
   int   dns[9];

   initial begin
      int prev_addr, hh, vv;
      vecs[0] = '{145, 32, 1'b1, 'h80, 4, 4, 2};
      vecs[1] = '{146, 32, 1'b1, 'hFF, 7, 7, 3};
      vecs[2] = '{272, 159, 1'b1, 'h5F, 2, 2, 1};
      vecs[3] = '{273, 32, 1'b1, 'hFF, 0, 0, 0};
      vecs[4] = '{144, 32, 1'b1, 'hFF, 0, 0, 0};
      vecs[5] = '{145, 31, 1'b1, 'hFF, 0, 0, 0};
      vecs[6] = '{145, 160, 1'b1, 'hFF, 0, 0, 0};
      vecs[7] = '{200, 50, 1'b0, 'hFF, 0, 0, 0};
      vecs[8] = '{180, 100, 1'b1, 'h20, 1, 1, 0};
      ups = '{16, 32, 48, 64, 80, 96, 112, 127, 127};
      dns = '{-16, -32, -48, -64, -80, -96, -112, -128, -128};

      for (int i = 0; i < 16384; i++) rom_mem[i] = 8'($urandom);
      {hcount, vcount} = '0;
      {video_on, hsync_in, vsync_in, btn_up, btn_dn} = '0;
      clear = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_rom_addr", int'(rom_addr), 0);
      checkOutput("reset_hsync", int'(hsync), 0);
      checkOutput("reset_vsync", int'(vsync), 0);
      checkOutput("reset_rgb", int'({red, green, blue}), 0);
      checkOutput("reset_brightness", int'(brightness), 0);
      clear = 1'b0;

      $display("[TB] vector table");
      for (int i = 0; i < 9; i++) begin
         prev_addr = int'(rom_addr);
         if (inImage(vecs[i].h, vecs[i].v, vecs[i].von))
            rom_mem[(vecs[i].v - V_START) * IMG_W + (vecs[i].h - H_START)] = 8'(vecs[i].data);
         applyStimulus(vecs[i].h, vecs[i].v, vecs[i].von, 1'b0, 1'b0);
         idle(2);
         checkOutput("vec_red", int'(red), vecs[i].r);
         checkOutput("vec_green", int'(green), vecs[i].g);
         checkOutput("vec_blue", int'(blue), vecs[i].b);
         if (!inImage(vecs[i].h, vecs[i].v, vecs[i].von))
            checkOutput("vec_addr_hold", int'(rom_addr), prev_addr);
      end

      $display("[TB] brightness up");
      for (int i = 0; i < 9; i++) begin
         press(1'b1, 1'b0);
         checkOutput("bright_before_frame", int'($signed(brightness)), i == 0 ? 0 : ups[i-1]);
         applyFrame();
         checkOutput("bright_up", int'($signed(brightness)), ups[i]);
      end
      checkPixel("sat_high", 150, 40, 'hF0, 7, 7, 3);
      press(1'b1, 1'b1);
      applyFrame();
      checkOutput("bright_simultaneous", int'($signed(brightness)), 127);

      $display("[TB] mid-line reset");
      applyStimulus(300, 100, 1'b1, 1'b0, 1'b1);
      applyStimulus(301, 100, 1'b1, 1'b1, 1'b0);
      #3;
      clear = 1'b1;
      #1;
      checkOutput("midreset_rom_addr", int'(rom_addr), 0);
      checkOutput("midreset_syncs", int'({hsync, vsync}), 0);
      checkOutput("midreset_rgb", int'({red, green, blue}), 0);
      checkOutput("midreset_brightness", int'(brightness), 0);
      @(posedge clk);
      #1;
      clear = 1'b0;
      pipe.delete();
      model_bright = 0;
      model_pending = 0;
      rom_mem[(60 - V_START) * IMG_W + (160 - H_START)] = 8'hE0;
      applyStimulus(160, 60, 1'b1, 1'b0, 1'b0);
      applyStimulus(161, 60, 1'b1, 1'b0, 1'b0);
      checkOutput("refill_still_dark", int'(red), 0);
      idle(1);
      checkOutput("refill_first_red", int'(red), 7);

      $display("[TB] brightness down");
      for (int i = 0; i < 9; i++) begin
         press(1'b0, 1'b1);
         applyFrame();
         checkOutput("bright_dn", int'($signed(brightness)), dns[i]);
      end
      checkPixel("sat_low", 170, 90, 'h40, 0, 0, 0);

      // btn_up rises so that its synchronized edge lands exactly on the frame-start cycle
      btn_up = 1'b1;
      idle(2);
      applyStimulus(0, 0, 1'b0, 1'b1, 1'b1);
      model_pending = 1;
      idle(3);
      btn_up = 1'b0;
      idle(4);
      checkOutput("edge_on_apply_held", int'($signed(brightness)), -128);
      applyFrame();
      checkOutput("edge_on_apply_next", int'($signed(brightness)), -112);

      $display("[TB] random lines");
      for (int line = 0; line < 6; line++) begin
         case ($urandom % 3)
            0: press(1'b1, 1'b0);
            1: press(1'b0, 1'b1);
            default: idle(1);
         endcase
         applyFrame();
         vv = int'($urandom_range(V_START - 2, V_START + IMG_H + 1));
         for (hh = 0; hh < 800; hh++)
            applyStimulus(hh, vv, ($urandom % 8) != 0, 1'($urandom), 1'($urandom));
         checkOutput("random_bright", int'($signed(brightness)), model_bright);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
